// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one register-bank port between requesters A (SPI) and B (I2C).
// Optional bank response timeout in WAIT is enabled by defining ARB_TIMEOUT_EN.
module reg_bank_arbiter #(
  parameter int REG_WIDTH      = 8,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 a_wr_rdn,
  input  logic [REG_WIDTH-1:0] a_addr,
  input  logic [REG_WIDTH-1:0] a_wdata,
  output logic                 a_ack,
  output logic                 a_err,
  output logic [REG_WIDTH-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_wr_rdn,
  input  logic [REG_WIDTH-1:0] b_addr,
  input  logic [REG_WIDTH-1:0] b_wdata,
  output logic                 b_ack,
  output logic                 b_err,
  output logic [REG_WIDTH-1:0] b_rdata,
  output logic                 bank_valid,
  output logic                 bank_wr_rdn,
  output logic [ADDR_W-1:0]    bank_addr,
  output logic [REG_WIDTH-1:0] bank_wdata,
  output logic                 bank_we,
  input  logic [REG_WIDTH-1:0] bank_rdata,
  input  logic                 bank_ack,
  input  logic                 bank_err,
  output logic [1:0]           grant,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic                   rr_last_q, rr_last_d;   // 1 = B was served last
  logic [1:0]             grant_q, grant_d;
  logic                   wr_q, wr_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [REG_WIDTH-1:0]   wdata_q, wdata_d;
  logic                   a_ack_q, a_ack_d, a_err_q, a_err_d;
  logic [REG_WIDTH-1:0]   a_rdata_q, a_rdata_d;
  logic                   b_ack_q, b_ack_d, b_err_q, b_err_d;
  logic [REG_WIDTH-1:0]   b_rdata_q, b_rdata_d;

  logic                   pick_b;
  logic                   timeout;
  logic                   resp_err;
  logic [REG_WIDTH-1:0]   resp_rdata;
  logic                   winner_req;
  logic                   unused_addr_bits;

  // B wins if it is the only requester, or on a tie when A was served last.
  assign pick_b     = b_req & (~a_req | ~rr_last_q);
  // A real bank response in the expiry cycle takes precedence over the timeout.
  assign resp_err   = bank_err | (timeout & ~bank_ack);
  assign resp_rdata = (wr_q | resp_err) ? '0 : bank_rdata;
  assign winner_req = grant_q[1] ? b_req : a_req;
  assign unused_addr_bits = ^{a_addr[REG_WIDTH-1:ADDR_W], b_addr[REG_WIDTH-1:ADDR_W]};

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_ISSUE) begin
      cnt_d = CNT_W'(TIMEOUT_CYCLES);
    end else if (state_q == S_WAIT && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout = (state_q == S_WAIT) && (cnt_q == CNT_W'(1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    grant_d   = grant_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_ack_d   = a_ack_q;
    a_err_d   = a_err_q;
    a_rdata_d = a_rdata_q;
    b_ack_d   = b_ack_q;
    b_err_d   = b_err_q;
    b_rdata_d = b_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (a_req | b_req) begin
          grant_d = pick_b ? 2'b10 : 2'b01;
          wr_d    = pick_b ? b_wr_rdn : a_wr_rdn;
          addr_d  = pick_b ? b_addr[ADDR_W-1:0] : a_addr[ADDR_W-1:0];
          wdata_d = pick_b ? b_wdata : a_wdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bank_ack | bank_err | timeout) begin
          if (grant_q[1]) begin
            b_ack_d   = 1'b1;
            b_err_d   = resp_err;
            b_rdata_d = resp_rdata;
          end else begin
            a_ack_d   = 1'b1;
            a_err_d   = resp_err;
            a_rdata_d = resp_rdata;
          end
          rr_last_d = grant_q[1];
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (!winner_req) begin
          a_ack_d   = 1'b0;
          a_err_d   = 1'b0;
          a_rdata_d = '0;
          b_ack_d   = 1'b0;
          b_err_d   = 1'b0;
          b_rdata_d = '0;
          grant_d   = '0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_last_q <= 1'b1;
      grant_q   <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_ack_q   <= 1'b0;
      a_err_q   <= 1'b0;
      a_rdata_q <= '0;
      b_ack_q   <= 1'b0;
      b_err_q   <= 1'b0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      grant_q   <= grant_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_ack_q   <= a_ack_d;
      a_err_q   <= a_err_d;
      a_rdata_q <= a_rdata_d;
      b_ack_q   <= b_ack_d;
      b_err_q   <= b_err_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_ack       = a_ack_q;
  assign a_err       = a_err_q;
  assign a_rdata     = a_rdata_q;
  assign b_ack       = b_ack_q;
  assign b_err       = b_err_q;
  assign b_rdata     = b_rdata_q;
  assign bank_valid  = (state_q == S_ISSUE);
  assign bank_wr_rdn = wr_q;
  assign bank_addr   = addr_q;
  assign bank_wdata  = wdata_q;
  assign bank_we     = bank_valid & wr_q;
  assign grant       = grant_q;
  assign busy        = (state_q != S_IDLE);

endmodule
